// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the M-mode trap-entry sequencer: CSR addresses, cause codes,
// mstatus bit positions and the sequencer state encoding.
package trap_sequencer_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int CAUSE_ILLEGAL = 2;
    localparam int CAUSE_ECALL   = 11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_EPC,
        ST_W_CAUSE,
        ST_W_STATUS,
        ST_REDIR
    } state_t;

endpackage

// File: rtl/trap_cause_encoder.sv
// Combinational trap acceptance and cause selection for the instruction in EX.
// Priority: illegal instruction > ECALL > machine external interrupt.
module trap_cause_encoder
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IRQ_CODE = 11
) (
    input  logic            valid_e,
    input  logic            ecall_e,
    input  logic            illegal_e,
    input  logic            mret_e,
    input  logic            irq,
    input  logic            mstatus_mie,
    input  logic            mie_meie,
    output logic            take,
    output logic [XLEN-1:0] cause
);

    logic exc;
    logic irq_ok;

    // An MRET in EX holds off the interrupt for one cycle so the return completes first.
    assign exc    = valid_e & (illegal_e | ecall_e);
    assign irq_ok = valid_e & irq & mstatus_mie & mie_meie & ~mret_e & ~exc;
    assign take   = exc | irq_ok;

    always_comb begin
        cause = '0;
        if (valid_e && illegal_e) begin
            cause = XLEN'(CAUSE_ILLEGAL);
        end else if (valid_e && ecall_e) begin
            cause = XLEN'(CAUSE_ECALL);
        end else if (irq_ok) begin
            cause = {1'b1, (XLEN-1)'(IRQ_CODE)};
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// M-mode trap-entry controller: squashes the pipeline, writes mepc/mcause/mstatus over the
// single CSR port, then redirects the PC. Define TRAP_VECTORED_EN for vectored interrupt entry.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IRQ_CODE = 11
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid_e,
    input  logic [XLEN-1:0] i_pc_e,
    input  logic            i_ecall_e,
    input  logic            i_illegal_e,
    input  logic            i_mret_e,
    input  logic            i_irq,
    input  logic [XLEN-1:0] i_mstatus,
    input  logic            i_mie_meie,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic            i_csr_ready,
    output logic            o_csr_we,
    output logic [11:0]     o_csr_addr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_pc_stall,
    output logic            o_if_id_flush,
    output logic            o_id_ex_flush,
    output logic            o_ex_mem_flush,
    output logic            o_pc_redirect,
    output logic [XLEN-1:0] o_pc_target,
    output logic            o_busy
);

    state_t            state_q;
    state_t            state_d;
    logic              take;
    logic              accept;
    logic [XLEN-1:0]   take_cause;
    logic [XLEN-1:0]   epc_q;
    logic [XLEN-1:0]   cause_q;
    logic [XLEN-1:0]   status_q;
    logic [XLEN-1:0]   status_wr;
    logic [XLEN-1:0]   mtvec_base;
    logic [XLEN-1:0]   target_addr;

    trap_cause_encoder #(
        .XLEN     (XLEN),
        .IRQ_CODE (IRQ_CODE)
    ) u_cause_encoder (
        .valid_e     (i_valid_e),
        .ecall_e     (i_ecall_e),
        .illegal_e   (i_illegal_e),
        .mret_e      (i_mret_e),
        .irq         (i_irq),
        .mstatus_mie (i_mstatus[MSTATUS_MIE]),
        .mie_meie    (i_mie_meie),
        .take        (take),
        .cause       (take_cause)
    );

    // Gating with reset keeps the squash outputs quiet while reset is held.
    assign accept = take & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && accept) begin
                epc_q    <= i_pc_e;
                cause_q  <= take_cause;
                status_q <= i_mstatus;
            end
        end
    end

    always_comb begin
        status_wr                                = status_q;
        status_wr[MSTATUS_MPIE]                  = status_q[MSTATUS_MIE];
        status_wr[MSTATUS_MIE]                   = 1'b0;
        status_wr[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    assign mtvec_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign target_addr = (i_mtvec[1:0] == 2'b01 && cause_q[XLEN-1])
                       ? mtvec_base + XLEN'(4 * IRQ_CODE)
                       : mtvec_base;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^i_mtvec[1:0];
    assign target_addr       = mtvec_base;
`endif

    always_comb begin
        state_d        = state_q;
        o_csr_we       = 1'b0;
        o_csr_addr     = '0;
        o_csr_wdata    = '0;
        o_pc_stall     = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        o_pc_redirect  = 1'b0;
        o_pc_target    = '0;
        o_busy         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    o_pc_stall     = 1'b1;
                    o_if_id_flush  = 1'b1;
                    o_id_ex_flush  = 1'b1;
                    o_ex_mem_flush = 1'b1;
                    state_d        = ST_W_EPC;
                end
            end
            ST_W_EPC: begin
                o_busy        = 1'b1;
                o_pc_stall    = 1'b1;
                o_if_id_flush = 1'b1;
                o_csr_we      = 1'b1;
                o_csr_addr    = CSR_MEPC;
                o_csr_wdata   = epc_q;
                if (i_csr_ready) state_d = ST_W_CAUSE;
            end
            ST_W_CAUSE: begin
                o_busy        = 1'b1;
                o_pc_stall    = 1'b1;
                o_if_id_flush = 1'b1;
                o_csr_we      = 1'b1;
                o_csr_addr    = CSR_MCAUSE;
                o_csr_wdata   = cause_q;
                if (i_csr_ready) state_d = ST_W_STATUS;
            end
            ST_W_STATUS: begin
                o_busy        = 1'b1;
                o_pc_stall    = 1'b1;
                o_if_id_flush = 1'b1;
                o_csr_we      = 1'b1;
                o_csr_addr    = CSR_MSTATUS;
                o_csr_wdata   = status_wr;
                if (i_csr_ready) state_d = ST_REDIR;
            end
            ST_REDIR: begin
                o_busy        = 1'b1;
                o_pc_stall    = 1'b1;
                o_if_id_flush = 1'b1;
                o_pc_redirect = 1'b1;
                o_pc_target   = target_addr;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer: table of accept vectors with full
// write/redirect sequence checks, plus hand-written backpressure, reset and back-to-back cases.
module tb_trap_sequencer;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid_e;
    logic [31:0] i_pc_e;
    logic        i_ecall_e;
    logic        i_illegal_e;
    logic        i_mret_e;
    logic        i_irq;
    logic [31:0] i_mstatus;
    logic        i_mie_meie;
    logic [31:0] i_mtvec;
    logic        i_csr_ready;
    logic        o_csr_we;
    logic [11:0] o_csr_addr;
    logic [31:0] o_csr_wdata;
    logic        o_pc_stall;
    logic        o_if_id_flush;
    logic        o_id_ex_flush;
    logic        o_ex_mem_flush;
    logic        o_pc_redirect;
    logic [31:0] o_pc_target;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    trap_sequencer #(.XLEN(32), .IRQ_CODE(11)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid_e      (i_valid_e),
        .i_pc_e         (i_pc_e),
        .i_ecall_e      (i_ecall_e),
        .i_illegal_e    (i_illegal_e),
        .i_mret_e       (i_mret_e),
        .i_irq          (i_irq),
        .i_mstatus      (i_mstatus),
        .i_mie_meie     (i_mie_meie),
        .i_mtvec        (i_mtvec),
        .i_csr_ready    (i_csr_ready),
        .o_csr_we       (o_csr_we),
        .o_csr_addr     (o_csr_addr),
        .o_csr_wdata    (o_csr_wdata),
        .o_pc_stall     (o_pc_stall),
        .o_if_id_flush  (o_if_id_flush),
        .o_id_ex_flush  (o_id_ex_flush),
        .o_ex_mem_flush (o_ex_mem_flush),
        .o_pc_redirect  (o_pc_redirect),
        .o_pc_target    (o_pc_target),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        valid;
        logic        ecall;
        logic        illegal;
        logic        mret;
        logic        irq;
        logic        meie;
        logic [31:0] pc;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic        take;
        logic [31:0] cause;
        logic [31:0] status;
        logic [31:0] target_base;
        logic [31:0] target_vec;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        i_valid_e   = 1'b0;
        i_pc_e      = 32'h0;
        i_ecall_e   = 1'b0;
        i_illegal_e = 1'b0;
        i_mret_e    = 1'b0;
        i_irq       = 1'b0;
        i_mstatus   = 32'h0;
        i_mie_meie  = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        i_valid_e   = v.valid;
        i_ecall_e   = v.ecall;
        i_illegal_e = v.illegal;
        i_mret_e    = v.mret;
        i_irq       = v.irq;
        i_mie_meie  = v.meie;
        i_pc_e      = v.pc;
        i_mstatus   = v.mstatus;
        i_mtvec     = v.mtvec;
    endtask

    // Called in the accept cycle; walks W_EPC, W_CAUSE, W_STATUS and stops in REDIR.
    task automatic runSequence(input logic [31:0] epc, input logic [31:0] cause,
                               input logic [31:0] status, input logic [31:0] target);
        @(posedge i_clk); #1;
        clearInputs();
        #1;
        checkOutput("epc_we", 32'(o_csr_we), 32'd1);
        checkOutput("epc_addr", 32'(o_csr_addr), 32'h341);
        checkOutput("epc_data", o_csr_wdata, epc);
        checkOutput("epc_busy", 32'(o_busy), 32'd1);
        checkOutput("epc_stall", 32'(o_pc_stall), 32'd1);
        checkOutput("epc_ifid", 32'(o_if_id_flush), 32'd1);
        checkOutput("epc_exmem", 32'(o_ex_mem_flush), 32'd0);
        @(posedge i_clk); #2;
        checkOutput("cause_addr", 32'(o_csr_addr), 32'h342);
        checkOutput("cause_data", o_csr_wdata, cause);
        @(posedge i_clk); #2;
        checkOutput("status_addr", 32'(o_csr_addr), 32'h300);
        checkOutput("status_data", o_csr_wdata, status);
        checkOutput("status_redir", 32'(o_pc_redirect), 32'd0);
        @(posedge i_clk); #2;
        checkOutput("redir", 32'(o_pc_redirect), 32'd1);
        checkOutput("redir_target", o_pc_target, target);
        checkOutput("redir_we", 32'(o_csr_we), 32'd0);
        checkOutput("redir_busy", 32'(o_busy), 32'd1);
    endtask

    initial begin
        vec_t v;
        logic [31:0] tgt;

        //            vld   ecall illeg mret  irq   meie  pc            mstatus       mtvec         take  cause         status        t_base        t_vec
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0008, 32'h0000_0200, 1'b1, 32'h0000_000B, 32'h0000_1880, 32'h0000_0200, 32'h0000_0200};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0008, 32'h0000_0200, 1'b1, 32'h8000_000B, 32'h0000_1880, 32'h0000_0200, 32'h0000_0200};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0200, 1'b0, 32'h0,          32'h0,          32'h0,          32'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0000, 32'h0000_0301, 1'b1, 32'h0000_0002, 32'h0000_1800, 32'h0000_0300, 32'h0000_0300};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0008, 32'h0000_0200, 1'b0, 32'h0,          32'h0,          32'h0,          32'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0048, 32'h0000_0008, 32'h0000_0200, 1'b0, 32'h0,          32'h0,          32'h0,          32'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_004C, 32'h0000_0008, 32'h0000_0200, 1'b0, 32'h0,          32'h0,          32'h0,          32'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0088, 32'h0000_0301, 1'b1, 32'h8000_000B, 32'h0000_1880, 32'h0000_0300, 32'h0000_032C};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0050, 32'h0000_0008, 32'h0000_0200, 1'b0, 32'h0,          32'h0,          32'h0,          32'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 32'h1000_0003, 1'b1, 32'h0000_0002, 32'hFFFF_FFF7, 32'h1000_0000, 32'h1000_0000};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_0008, 32'h0000_0200, 1'b1, 32'h0000_000B, 32'h0000_1880, 32'h0000_0200, 32'h0000_0200};

        clearInputs();
        i_mtvec     = 32'h0;
        i_csr_ready = 1'b1;
        i_rst_n     = 1'b0;

        // Reset state: a trap presented during reset must not reach the outputs.
        i_valid_e  = 1'b1;
        i_ecall_e  = 1'b1;
        #12;
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_exmem", 32'(o_ex_mem_flush), 32'd0);
        checkOutput("rst_stall", 32'(o_pc_stall), 32'd0);
        checkOutput("rst_we", 32'(o_csr_we), 32'd0);
        checkOutput("rst_redir", 32'(o_pc_redirect), 32'd0);
        clearInputs();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
`ifdef TRAP_VECTORED_EN
            tgt = v.target_vec;
`else
            tgt = v.target_base;
`endif
            @(posedge i_clk); #1;
            applyStimulus(v);
            #1;
            checkOutput($sformatf("v%0d_accept", i), 32'(o_ex_mem_flush), 32'(v.take));
            checkOutput($sformatf("v%0d_idex", i), 32'(o_id_ex_flush), 32'(v.take));
            checkOutput($sformatf("v%0d_stall", i), 32'(o_pc_stall), 32'(v.take));
            checkOutput($sformatf("v%0d_idle_busy", i), 32'(o_busy), 32'd0);
            if (v.take) begin
                runSequence(v.pc, v.cause, v.status, tgt);
            end
            @(posedge i_clk); #1;
            clearInputs();
            #1;
            checkOutput($sformatf("v%0d_after_busy", i), 32'(o_busy), 32'd0);
            checkOutput($sformatf("v%0d_after_redir", i), 32'(o_pc_redirect), 32'd0);
        end

        // MRET in EX blocks the interrupt for one cycle; it is taken once MRET leaves.
        @(posedge i_clk); #1;
        i_valid_e = 1'b1; i_irq = 1'b1; i_mie_meie = 1'b1; i_mret_e = 1'b1;
        i_pc_e = 32'h0000_0060; i_mstatus = 32'h0000_0008; i_mtvec = 32'h0000_0200;
        #1;
        checkOutput("mret_block", 32'(o_ex_mem_flush), 32'd0);
        @(posedge i_clk); #1;
        i_mret_e = 1'b0; i_pc_e = 32'h0000_0064;
        #1;
        checkOutput("mret_retry", 32'(o_ex_mem_flush), 32'd1);
        runSequence(32'h0000_0064, 32'h8000_000B, 32'h0000_1880, 32'h0000_0200);

        // Back-to-back: the cycle after REDIR is IDLE and accepts a new trap.
        @(posedge i_clk); #1;
        i_valid_e = 1'b1; i_ecall_e = 1'b1; i_pc_e = 32'h0000_0700; i_mstatus = 32'h0000_0000;
        #1;
        checkOutput("b2b_accept", 32'(o_ex_mem_flush), 32'd1);
        runSequence(32'h0000_0700, 32'h0000_000B, 32'h0000_1800, 32'h0000_0200);

        // Backpressure: ready low for three cycles in W_CAUSE delays redirect to cycle 7.
        @(posedge i_clk); #1;
        clearInputs();
        i_valid_e = 1'b1; i_ecall_e = 1'b1; i_pc_e = 32'h0000_0500;
        i_mstatus = 32'h0000_0008; i_mtvec = 32'h0000_0400;
        #1;
        checkOutput("bp_accept", 32'(o_ex_mem_flush), 32'd1);
        @(posedge i_clk); #1;
        clearInputs();
        #1;
        checkOutput("bp_epc_addr", 32'(o_csr_addr), 32'h341);
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            i_csr_ready = 1'b0;
            #1;
            checkOutput($sformatf("bp_hold%0d_addr", c), 32'(o_csr_addr), 32'h342);
            checkOutput($sformatf("bp_hold%0d_data", c), o_csr_wdata, 32'h0000_000B);
            checkOutput($sformatf("bp_hold%0d_we", c), 32'(o_csr_we), 32'd1);
            checkOutput($sformatf("bp_hold%0d_redir", c), 32'(o_pc_redirect), 32'd0);
        end
        @(posedge i_clk); #1;
        i_csr_ready = 1'b1;
        #1;
        checkOutput("bp_release_addr", 32'(o_csr_addr), 32'h342);
        @(posedge i_clk); #2;
        checkOutput("bp_status_addr", 32'(o_csr_addr), 32'h300);
        checkOutput("bp_status_data", o_csr_wdata, 32'h0000_1880);
        @(posedge i_clk); #2;
        checkOutput("bp_redir", 32'(o_pc_redirect), 32'd1);
        checkOutput("bp_target", o_pc_target, 32'h0000_0400);

        // Reset asserted mid-sequence forces every output low immediately.
        @(posedge i_clk); #1;
        i_valid_e = 1'b1; i_ecall_e = 1'b1; i_pc_e = 32'h0000_0600; i_mstatus = 32'h0000_0008;
        @(posedge i_clk); #1;
        clearInputs();
        @(posedge i_clk); #2;
        checkOutput("rstmid_pre_addr", 32'(o_csr_addr), 32'h342);
        i_rst_n = 1'b0;
        #1;
        checkOutput("rstmid_we", 32'(o_csr_we), 32'd0);
        checkOutput("rstmid_addr", 32'(o_csr_addr), 32'h0);
        checkOutput("rstmid_data", o_csr_wdata, 32'h0);
        checkOutput("rstmid_busy", 32'(o_busy), 32'd0);
        checkOutput("rstmid_stall", 32'(o_pc_stall), 32'd0);
        checkOutput("rstmid_ifid", 32'(o_if_id_flush), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #2;
        checkOutput("rstmid_idle_busy", 32'(o_busy), 32'd0);
        checkOutput("rstmid_idle_we", 32'(o_csr_we), 32'd0);
        @(posedge i_clk); #1;
        i_valid_e = 1'b1; i_illegal_e = 1'b1; i_pc_e = 32'h0000_0604; i_mstatus = 32'h0000_0008;
        #1;
        checkOutput("rstmid_reaccept", 32'(o_ex_mem_flush), 32'd1);
        runSequence(32'h0000_0604, 32'h0000_0002, 32'h0000_1880, 32'h0000_0400);

        @(posedge i_clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
